pc_fetch_sequencer: RTL and testbench

Owns the architectural program counter and drives it to the next-PC ALU as `pcCur`. It takes the ALU's `pcNext` back, runs the instruction-memory read handshake, and hands fetched words to the decoder with a valid/ready handshake. It also handles the single-level interrupt entry and return, and the halt at the top of program space (`INTERRUPT_CONTROL`-1).

---
 rtl/pc_fetch_sequencer.sv | 112 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter owner, instruction fetch handshake, interrupt entry/return and halt
module pc_fetch_sequencer #(
    parameter int               WIDTH             = 16,
    parameter logic [WIDTH-1:0] RESET_PC          = 16'h0000,
    parameter logic [WIDTH-1:0] INTERRUPT_CONTROL = 16'h5FFF,
    parameter logic [WIDTH-1:0] INT_VECTOR        = 16'h5F00
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] pcCur,
    input  logic [WIDTH-1:0] pcNext,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             stall,
    input  logic             reti,
    input  logic             irq,
    output logic             irq_ack,
    output logic [WIDTH-1:0] epc,
    output logic             in_isr
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    localparam logic [WIDTH-1:0] HALT_PC = INTERRUPT_CONTROL - {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, stateD;
    logic [WIDTH-1:0] pcCurD, instrD, epcD;
    logic             instrValidD, inIsrD, irqAckD;
    logic             accept;

    assign accept    = instr_valid & instr_ready & ~stall;
    assign imem_req  = (state == FETCH);
    assign imem_addr = pcCur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pcCur       <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            irq_ack     <= 1'b0;
            epc         <= '0;
            in_isr      <= 1'b0;
        end else begin
            state       <= stateD;
            pcCur       <= pcCurD;
            instr       <= instrD;
            instr_valid <= instrValidD;
            irq_ack     <= irqAckD;
            epc         <= epcD;
            in_isr      <= inIsrD;
        end
    end

    always_comb begin
        stateD      = state;
        pcCurD      = pcCur;
        instrD      = instr;
        instrValidD = instr_valid;
        epcD        = epc;
        inIsrD      = in_isr;
        irqAckD     = 1'b0;
        case (state)
            IDLE: stateD = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instrD      = imem_data;
                    instrValidD = 1'b1;
                    stateD      = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    instrValidD = 1'b0;
                    if (reti && in_isr) begin
                        pcCurD = epc;
                        inIsrD = 1'b0;
                        stateD = FETCH;
                    end else if (irq && !in_isr) begin
                        // Return point is the instruction that would have followed the accepted one
                        epcD    = pcNext;
                        pcCurD  = INT_VECTOR;
                        inIsrD  = 1'b1;
                        irqAckD = 1'b1;
                        stateD  = FETCH;
                    end else if (pcNext == pcCur && pcCur == HALT_PC) begin
                        stateD = HALT;
                    end else begin
                        pcCurD = pcNext;
                        stateD = FETCH;
                    end
                end
            end
            HALT: begin
                if (irq) begin
                    epcD    = pcCur;
                    pcCurD  = INT_VECTOR;
                    inIsrD  = 1'b1;
                    irqAckD = 1'b1;
                    stateD  = FETCH;
                end
            end
            default: stateD = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - vector table, directed interrupt/halt/reset sequences and randomized model check
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pcCur, pcNext = '0, imem_addr, imem_data = '0, instr, epc;
    logic        imem_req, imem_ready = 1'b0, instr_valid, instr_ready = 1'b0;
    logic        stall = 1'b0, reti = 1'b0, irq = 1'b0, irq_ack, in_isr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk(clk), .reset(reset), .pcCur(pcCur), .pcNext(pcNext),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .stall(stall),
        .reti(reti), .irq(irq), .irq_ack(irq_ack), .epc(epc), .in_isr(in_isr)
    );

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [15:0] data;
        logic        iRdy;
        logic        stl;
        logic [15:0] nxt;
        logic [15:0] ePc;
        logic        eReq;
        logic        eValid;
        logic [15:0] eInstr;
    } vec_t;

    vec_t vecs[17];

    // Fetch one instruction with the given word, then accept it with the given next PC
    task automatic runInstr(input logic [15:0] data, input logic [15:0] nxt, input logic doReti);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk1("fetch_req_timeout", imem_req, 1'b1);
        imem_ready = 1'b1;
        imem_data  = data;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        chk1("hold_valid", instr_valid, 1'b1);
        chk16("hold_instr", instr, data);
        instr_ready = 1'b1;
        pcNext      = nxt;
        reti        = doReti;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        reti        = 1'b0;
    endtask

    // Reference model: spec rules applied to plain variables, one call per clock
    logic [15:0] mPc, mEpc, mInstr;
    logic        mValid, mInIsr, mAck, mIdle, mFetch, mHalt;

    task automatic modelReset();
        mPc = 16'h0000; mEpc = '0; mInstr = '0;
        mValid = 0; mInIsr = 0; mAck = 0; mIdle = 1; mFetch = 0; mHalt = 0;
    endtask

    task automatic modelEnter(input logic [15:0] ret);
        mEpc = ret; mPc = 16'h5F00; mInIsr = 1; mAck = 1; mFetch = 1;
    endtask

    task automatic modelStep();
        logic acc;
        acc  = mValid && instr_ready && !stall;
        mAck = 0;
        if (reset) modelReset();
        else if (mIdle) begin
            mIdle = 0; mFetch = 1;
        end else if (mFetch) begin
            if (imem_ready) begin
                mInstr = imem_data; mValid = 1; mFetch = 0;
            end
        end else if (mValid) begin
            if (acc) begin
                mValid = 0;
                if (reti && mInIsr) begin
                    mPc = mEpc; mInIsr = 0; mFetch = 1;
                end else if (irq && !mInIsr) modelEnter(pcNext);
                else if (pcNext == mPc && mPc == 16'h5FFE) mHalt = 1;
                else begin
                    mPc = pcNext; mFetch = 1;
                end
            end
        end else if (mHalt) begin
            if (irq) begin
                mHalt = 0;
                modelEnter(mPc);
            end
        end
    endtask

    task automatic checkModel();
        chk16("rnd_pc", pcCur, mPc);
        chk1("rnd_req", imem_req, mFetch);
        if (mFetch) chk16("rnd_addr", imem_addr, mPc);
        chk16("rnd_instr", instr, mInstr);
        chk1("rnd_valid", instr_valid, mValid);
        chk1("rnd_ack", irq_ack, mAck);
        chk16("rnd_epc", epc, mEpc);
        chk1("rnd_isr", in_isr, mInIsr);
    endtask

    initial begin
        //           rst rdy data      iRdy stl nxt       ePc       eReq eVal eInstr
        vecs[0]  = '{0, 1, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000};
        vecs[1]  = '{0, 1, 16'h1000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000};
        vecs[2]  = '{0, 0, 16'h0000, 1, 0, 16'h0001, 16'h0000, 0, 1, 16'h1000};
        vecs[3]  = '{0, 1, 16'h1001, 0, 0, 16'h0001, 16'h0001, 1, 0, 16'h1000};
        vecs[4]  = '{0, 0, 16'h0000, 1, 0, 16'h0002, 16'h0001, 0, 1, 16'h1001};
        vecs[5]  = '{0, 1, 16'h1002, 0, 0, 16'h0002, 16'h0002, 1, 0, 16'h1001};
        vecs[6]  = '{0, 0, 16'h0000, 1, 0, 16'h0003, 16'h0002, 0, 1, 16'h1002};
        vecs[7]  = '{0, 0, 16'h0000, 0, 0, 16'h0003, 16'h0003, 1, 0, 16'h1002};
        vecs[8]  = '{0, 0, 16'h0000, 0, 0, 16'h0003, 16'h0003, 1, 0, 16'h1002};
        vecs[9]  = '{0, 0, 16'h0000, 0, 0, 16'h0003, 16'h0003, 1, 0, 16'h1002};
        vecs[10] = '{0, 1, 16'h2003, 0, 0, 16'h0003, 16'h0003, 1, 0, 16'h1002};
        vecs[11] = '{0, 1, 16'hDEAD, 1, 1, 16'h0004, 16'h0003, 0, 1, 16'h2003};
        vecs[12] = '{0, 1, 16'hDEAD, 1, 1, 16'h0004, 16'h0003, 0, 1, 16'h2003};
        vecs[13] = '{0, 1, 16'hDEAD, 1, 1, 16'h0004, 16'h0003, 0, 1, 16'h2003};
        vecs[14] = '{0, 1, 16'hDEAD, 1, 1, 16'h0004, 16'h0003, 0, 1, 16'h2003};
        vecs[15] = '{0, 0, 16'h0000, 1, 0, 16'h0004, 16'h0003, 0, 1, 16'h2003};
        vecs[16] = '{0, 0, 16'h0000, 0, 0, 16'h0004, 16'h0004, 1, 0, 16'h2003};

        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            reset       = vecs[i].rst;
            imem_ready  = vecs[i].rdy;
            imem_data   = vecs[i].data;
            instr_ready = vecs[i].iRdy;
            stall       = vecs[i].stl;
            pcNext      = vecs[i].nxt;
            @(negedge clk);
            chk16($sformatf("vec%0d_pc", i), pcCur, vecs[i].ePc);
            chk1($sformatf("vec%0d_req", i), imem_req, vecs[i].eReq);
            if (vecs[i].eReq) chk16($sformatf("vec%0d_addr", i), imem_addr, vecs[i].ePc);
            chk1($sformatf("vec%0d_valid", i), instr_valid, vecs[i].eValid);
            chk16($sformatf("vec%0d_instr", i), instr, vecs[i].eInstr);
            chk1($sformatf("vec%0d_ack", i), irq_ack, 1'b0);
            chk1($sformatf("vec%0d_isr", i), in_isr, 1'b0);
            chk16($sformatf("vec%0d_epc", i), epc, 16'h0000);
            @(posedge clk); #1;
        end
        imem_ready = 1'b0; instr_ready = 1'b0; stall = 1'b0;

        // Jump, then interrupt entry on the instruction after the jump
        runInstr(16'h3004, 16'h0010, 1'b0);
        chk16("pc_0010", pcCur, 16'h0010);
        runInstr(16'h3010, 16'h1234, 1'b0);
        chk1("jump_req", imem_req, 1'b1);
        chk16("jump_addr", imem_addr, 16'h1234);
        irq = 1'b1;
        runInstr(16'h3234, 16'h1235, 1'b0);
        chk1("irq_ack_pulse", irq_ack, 1'b1);
        chk16("irq_epc", epc, 16'h1235);
        chk16("irq_pc", pcCur, 16'h5F00);
        chk1("irq_isr", in_isr, 1'b1);
        @(posedge clk); #1;
        chk1("irq_ack_drop", irq_ack, 1'b0);

        // Nested irq ignored, reti wins over irq, then the held irq re-enters
        runInstr(16'h4000, 16'h5F01, 1'b0);
        chk16("nested_pc", pcCur, 16'h5F01);
        chk1("nested_isr", in_isr, 1'b1);
        chk1("nested_ack", irq_ack, 1'b0);
        chk16("nested_epc", epc, 16'h1235);
        runInstr(16'h4001, 16'h5F02, 1'b1);
        chk16("reti_pc", pcCur, 16'h1235);
        chk1("reti_isr", in_isr, 1'b0);
        chk1("reti_ack", irq_ack, 1'b0);
        runInstr(16'h3235, 16'h1236, 1'b0);
        chk1("reenter_ack", irq_ack, 1'b1);
        chk16("reenter_epc", epc, 16'h1236);
        chk16("reenter_pc", pcCur, 16'h5F00);
        irq = 1'b0;
        runInstr(16'h4002, 16'h0000, 1'b1);
        chk16("ret2_pc", pcCur, 16'h1236);
        chk1("ret2_isr", in_isr, 1'b0);

        // Halt at top of program space, then leave via irq
        runInstr(16'h3236, 16'h5FFE, 1'b0);
        chk16("pc_5ffe", pcCur, 16'h5FFE);
        runInstr(16'h5555, 16'h5FFE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk1("halt_req", imem_req, 1'b0);
            chk1("halt_valid", instr_valid, 1'b0);
            chk16("halt_pc", pcCur, 16'h5FFE);
            @(posedge clk); #1;
        end
        irq = 1'b1;
        @(posedge clk); #1;
        irq = 1'b0;
        chk1("halt_irq_ack", irq_ack, 1'b1);
        chk16("halt_irq_epc", epc, 16'h5FFE);
        chk16("halt_irq_pc", pcCur, 16'h5F00);
        chk1("halt_irq_isr", in_isr, 1'b1);
        chk1("halt_irq_req", imem_req, 1'b1);
        chk16("halt_irq_addr", imem_addr, 16'h5F00);

        // Reset in FETCH with data arriving the cycle after
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        imem_ready = 1'b1;
        imem_data  = 16'hDEAD;
        chk1("rst_req", imem_req, 1'b0);
        chk16("rst_pc", pcCur, 16'h0000);
        chk1("rst_valid", instr_valid, 1'b0);
        chk16("rst_instr", instr, 16'h0000);
        chk1("rst_ack", irq_ack, 1'b0);
        chk16("rst_epc", epc, 16'h0000);
        chk1("rst_isr", in_isr, 1'b0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        chk16("rst_late_instr", instr, 16'h0000);
        chk1("rst_late_valid", instr_valid, 1'b0);
        chk1("rst_refetch_req", imem_req, 1'b1);
        chk16("rst_refetch_addr", imem_addr, 16'h0000);

        // Randomized run against the reference model
        reset = 1'b1;
        @(posedge clk); #1;
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            reset       = ($urandom_range(63) == 0);
            imem_ready  = $urandom_range(1);
            imem_data   = 16'($urandom);
            instr_ready = ($urandom_range(9) < 7);
            stall       = ($urandom_range(3) == 0);
            reti        = ($urandom_range(4) == 0);
            irq         = ($urandom_range(19) < 3);
            r = $urandom_range(99);
            if (r < 60)      pcNext = mPc + 16'h0001;
            else if (r < 70) pcNext = 16'h5FFE;
            else if (r < 85) pcNext = mPc;
            else             pcNext = 16'($urandom);
            @(negedge clk);
            checkModel();
            modelStep();
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
